// File: rtl/vga_timing_if.sv
// vga_timing_if: raster position and sync/blank flags from the timing generator
//   hcount/vcount : 11-bit pixel and line position
//   hsync/vsync   : active-high sync pulses
//   hblnk/vblnk   : high outside the visible area
//   frame_start   : high exactly at position (0,0)
interface vga_timing_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic        frame_start;
    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: registered VGA raster counters with sync/blank flags
//   pclk  : pixel clock, all state changes on its rising edge
//   rst   : synchronous active-high reset, forces position (0,0)
//   tim_o : hcount/vcount, hsync/vsync, hblnk/vblnk, frame_start (all registered)
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_TOTAL  = 1056,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_TOTAL  = 628
) (
    input  logic pclk,
    input  logic rst,
    vga_timing_if.master tim_o
);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] H_SS   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SS   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SE   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] hcount_q, hcount_d, vcount_q, vcount_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d, vblnk_q, vblnk_d;
    logic        frame_start_q, frame_start_d;

    // Flags are decoded from the next counts so they register in step with them.
    always_comb begin
        hcount_d      = (hcount_q == H_LAST) ? '0 : hcount_q + 11'd1;
        vcount_d      = (hcount_q != H_LAST) ? vcount_q : (vcount_q == V_LAST) ? '0 : vcount_q + 11'd1;
        hblnk_d       = hcount_d >= H_ACT;
        hsync_d       = (hcount_d >= H_SS) && (hcount_d < H_SE);
        vblnk_d       = vcount_d >= V_ACT;
        vsync_d       = (vcount_d >= V_SS) && (vcount_d < V_SE);
        frame_start_d = (hcount_d == '0) && (vcount_d == '0);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b1;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign tim_o.hcount      = hcount_q;
    assign tim_o.vcount      = vcount_q;
    assign tim_o.hsync       = hsync_q;
    assign tim_o.vsync       = vsync_q;
    assign tim_o.hblnk       = hblnk_q;
    assign tim_o.vblnk       = vblnk_q;
    assign tim_o.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of default, small and 640x480 timing instances
module tb_vga_timing_gen;
    logic pclk = 1'b0;
    logic rst_d = 1'b1;
    logic rst_s = 1'b1;
    logic rst_v = 1'b1;
    int cnt = 0;
    int errs = 0;
    int hd = 0;
    int sh = 0;
    int sv = 0;

    always #5 pclk = ~pclk;

    vga_timing_if if_d ();
    vga_timing_if if_s ();
    vga_timing_if if_v ();

    vga_timing_gen dut_d (.pclk(pclk), .rst(rst_d), .tim_o(if_d));

    // Small raster: hsync 20..25, vsync lines 12..14, frame 30*18 = 540 cycles.
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_TOTAL(30),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_TOTAL(18)
    ) dut_s (.pclk(pclk), .rst(rst_s), .tim_o(if_s));

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_TOTAL(800),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_TOTAL(525)
    ) dut_v (.pclk(pclk), .rst(rst_v), .tim_o(if_v));

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic step_s;
        tick();
        sv = (sh == 29) ? ((sv == 17) ? 0 : sv + 1) : sv;
        sh = (sh == 29) ? 0 : sh + 1;
    endtask

    task automatic goto_s(input int v, input int h);
        while (sv != v || sh != h) step_s();
    endtask

    task automatic test_reset;
        rst_d = 1'b1;
        repeat (3) tick();
        cnt++; if ({if_d.hcount, if_d.vcount} !== 22'd0) begin errs++; $display("FAIL reset_counts got h=%0d v=%0d want 0 0", if_d.hcount, if_d.vcount); end
        cnt++; if ({if_d.hsync, if_d.vsync, if_d.hblnk, if_d.vblnk, if_d.frame_start} !== 5'b00001) begin errs++; $display("FAIL reset_flags got %b want 00001", {if_d.hsync, if_d.vsync, if_d.hblnk, if_d.vblnk, if_d.frame_start}); end
        rst_d = 1'b0;
        cnt++; if ({if_d.hcount, if_d.frame_start} !== 12'd1) begin errs++; $display("FAIL release_hold got h=%0d fs=%b want 0 1", if_d.hcount, if_d.frame_start); end
        tick();
        hd = 1;
        cnt++; if (if_d.hcount !== 11'd1) begin errs++; $display("FAIL release_hcount got %0d want 1", if_d.hcount); end
        cnt++; if ({if_d.vcount, if_d.frame_start} !== 12'd0) begin errs++; $display("FAIL release_fs got v=%0d fs=%b want 0 0", if_d.vcount, if_d.frame_start); end
    endtask

    task automatic test_line_boundary;
        int tg[8] = '{799, 800, 839, 840, 967, 968, 1055, 0};
        logic hb[8] = '{0, 1, 1, 1, 1, 1, 1, 0};
        logic hs[8] = '{0, 0, 0, 1, 1, 0, 0, 0};
        int ev[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            while (hd != tg[i]) begin
                tick();
                hd = (hd == 1055) ? 0 : hd + 1;
            end
            cnt++; if (if_d.hcount !== 11'(tg[i]) || if_d.vcount !== 11'(ev[i])) begin errs++; $display("FAIL line_pos%0d got h=%0d v=%0d want %0d %0d", i, if_d.hcount, if_d.vcount, tg[i], ev[i]); end
            cnt++; if ({if_d.hblnk, if_d.hsync, if_d.vblnk, if_d.vsync, if_d.frame_start} !== {hb[i], hs[i], 3'b000}) begin errs++; $display("FAIL line_flags%0d got %b want %b", i, {if_d.hblnk, if_d.hsync, if_d.vblnk, if_d.vsync, if_d.frame_start}, {hb[i], hs[i], 3'b000}); end
        end
    endtask

    task automatic test_mid_line_reset;
        while (hd != 500) begin
            tick();
            hd = (hd == 1055) ? 0 : hd + 1;
        end
        rst_d = 1'b1;
        tick();
        rst_d = 1'b0;
        cnt++; if ({if_d.hcount, if_d.vcount} !== 22'd0) begin errs++; $display("FAIL midline_counts got h=%0d v=%0d want 0 0", if_d.hcount, if_d.vcount); end
        cnt++; if ({if_d.hsync, if_d.vsync, if_d.hblnk, if_d.vblnk, if_d.frame_start} !== 5'b00001) begin errs++; $display("FAIL midline_flags got %b want 00001", {if_d.hsync, if_d.vsync, if_d.hblnk, if_d.vblnk, if_d.frame_start}); end
        tick();
        cnt++; if (if_d.hcount !== 11'd1) begin errs++; $display("FAIL midline_resume got %0d want 1", if_d.hcount); end
    endtask

    task automatic test_frame_boundary;
        int tv[8] = '{9, 10, 11, 12, 14, 15, 17, 0};
        int th[8] = '{29, 0, 29, 0, 29, 0, 29, 0};
        logic [4:0] ef[8] = '{5'b00100, 5'b10000, 5'b10100, 5'b11000, 5'b11100, 5'b10000, 5'b10100, 5'b00001};
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        sh = 0;
        sv = 0;
        for (int i = 0; i < 8; i++) begin
            goto_s(tv[i], th[i]);
            cnt++; if (if_s.vcount !== 11'(tv[i]) || if_s.hcount !== 11'(th[i])) begin errs++; $display("FAIL frame_pos%0d got v=%0d h=%0d want %0d %0d", i, if_s.vcount, if_s.hcount, tv[i], th[i]); end
            cnt++; if ({if_s.vblnk, if_s.vsync, if_s.hblnk, if_s.hsync, if_s.frame_start} !== ef[i]) begin errs++; $display("FAIL frame_flags%0d got %b want %b", i, {if_s.vblnk, if_s.vsync, if_s.hblnk, if_s.hsync, if_s.frame_start}, ef[i]); end
        end
    endtask

    task automatic test_full_frame;
        int last = 0;
        int nfs = 0;
        int hpul = 0;
        int hw = 0;
        int vcyc = 0;
        logic hprev = 1'b0;
        for (int c = 1; c <= 1080; c++) begin
            step_s();
            if (if_s.frame_start) begin
                nfs++;
                cnt++; if (c - last != 540) begin errs++; $display("FAIL frame_period got %0d want 540", c - last); end
                cnt++; if (hpul != 18) begin errs++; $display("FAIL hsync_pulses got %0d want 18", hpul); end
                cnt++; if (vcyc != 90) begin errs++; $display("FAIL vsync_cycles got %0d want 90", vcyc); end
                last = c;
                hpul = 0;
                vcyc = 0;
            end
            if (if_s.hsync && !hprev) hpul++;
            hw = if_s.hsync ? hw + 1 : hw;
            if (!if_s.hsync && hprev) begin
                cnt++; if (hw != 6) begin errs++; $display("FAIL hsync_width got %0d want 6", hw); end
                hw = 0;
            end
            if (if_s.vsync) vcyc++;
            hprev = if_s.hsync;
        end
        cnt++; if (nfs != 2) begin errs++; $display("FAIL frame_count got %0d want 2", nfs); end
    endtask

    task automatic test_mid_frame_reset;
        int c = 0;
        goto_s(13, 22);
        cnt++; if ({if_s.vblnk, if_s.vsync, if_s.hblnk, if_s.hsync, if_s.frame_start} !== 5'b11110) begin errs++; $display("FAIL preset_flags got %b want 11110", {if_s.vblnk, if_s.vsync, if_s.hblnk, if_s.hsync, if_s.frame_start}); end
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        sh = 0;
        sv = 0;
        cnt++; if ({if_s.hcount, if_s.vcount} !== 22'd0) begin errs++; $display("FAIL midframe_counts got h=%0d v=%0d want 0 0", if_s.hcount, if_s.vcount); end
        cnt++; if ({if_s.hsync, if_s.vsync, if_s.hblnk, if_s.vblnk, if_s.frame_start} !== 5'b00001) begin errs++; $display("FAIL midframe_flags got %b want 00001", {if_s.hsync, if_s.vsync, if_s.hblnk, if_s.vblnk, if_s.frame_start}); end
        do begin
            step_s();
            c++;
        end while (!if_s.frame_start && c < 1200);
        cnt++; if (c != 540) begin errs++; $display("FAIL midframe_period got %0d want 540", c); end
    endtask

    task automatic test_params_vga;
        int h = 0;
        int tg[8] = '{639, 640, 655, 656, 751, 752, 799, 0};
        logic hb[8] = '{0, 1, 1, 1, 1, 1, 1, 0};
        logic hs[8] = '{0, 0, 0, 1, 1, 0, 0, 0};
        int ev[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        rst_v = 1'b1;
        tick();
        rst_v = 1'b0;
        for (int i = 0; i < 8; i++) begin
            while (h != tg[i]) begin
                tick();
                h = (h == 799) ? 0 : h + 1;
            end
            cnt++; if (if_v.hcount !== 11'(tg[i]) || if_v.vcount !== 11'(ev[i])) begin errs++; $display("FAIL vga_pos%0d got h=%0d v=%0d want %0d %0d", i, if_v.hcount, if_v.vcount, tg[i], ev[i]); end
            cnt++; if ({if_v.hblnk, if_v.hsync, if_v.vblnk, if_v.vsync} !== {hb[i], hs[i], 2'b00}) begin errs++; $display("FAIL vga_flags%0d got %b want %b", i, {if_v.hblnk, if_v.hsync, if_v.vblnk, if_v.vsync}, {hb[i], hs[i], 2'b00}); end
        end
    endtask

    initial begin
        test_reset();
        test_line_boundary();
        test_mid_line_reset();
        test_frame_boundary();
        test_full_frame();
        test_mid_frame_reset();
        test_params_vga();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
        $finish;
    end
endmodule
